// File: rtl/booth_unload_pkg.sv
// Shared definitions for the multiplier unload path: default product and word
// widths, plus the unload FSM state encoding.
package booth_unload_pkg;

  localparam int PW_DEFAULT = 448;
  localparam int WW_DEFAULT = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/booth_unload_slot.sv
// One product-wide holding register with a load enable and a full flag.
// Used as the PENDING slot behind the streaming ACTIVE register.
module booth_unload_slot
  import booth_unload_pkg::*;
#(
  parameter int PW = PW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  logic [PW-1:0] d,
  output logic [PW-1:0] q,
  output logic          full
);

  // Load wins over clear so a same-cycle refill keeps the slot occupied.
  always_ff @(posedge clk) begin
    if (rst)       full <= 1'b0;
    else if (load) full <= 1'b1;
    else if (clr)  full <= 1'b0;
  end

  // NOTE: the wide data register has no reset; it is only ever read while full=1.
  always_ff @(posedge clk) begin
    if (load) q <= d;
  end

endmodule

// File: rtl/booth_unload.sv
// Unloads a wide product as NW words of WW bits, least-significant first,
// with one pending product buffered behind the one being streamed.
module booth_unload
  import booth_unload_pkg::*;
#(
  parameter int PW = PW_DEFAULT,
  parameter int WW = WW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_valid,
  input  logic [PW-1:0] p_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [WW-1:0] o_data,
  output logic          o_last,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int NW = PW / WW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  state_t        state;
  logic [PW-1:0] active;
  logic [IW-1:0] idx;

  logic [PW-1:0] pend_q;
  logic          pend_full;
  logic          pend_load;
  logic          pend_clr;

  logic          streaming;
  logic          xfer;
  logic          last_xfer;
  logic          drop;

  always_comb begin
    streaming = (state == STREAM);
    xfer      = streaming && o_ready;
    last_xfer = xfer && (idx == LAST_IDX);
    // On a last-word transfer a full PENDING drains into ACTIVE, so it can
    // refill in the same cycle; otherwise it only accepts when empty.
    pend_load = streaming && p_valid && (last_xfer ? pend_full : !pend_full);
    pend_clr  = last_xfer && pend_full && !p_valid;
    drop      = streaming && p_valid && pend_full && !last_xfer;
  end

  booth_unload_slot #(.PW(PW)) u_pending (
    .clk  (clk),
    .rst  (rst),
    .load (pend_load),
    .clr  (pend_clr),
    .d    (p_data),
    .q    (pend_q),
    .full (pend_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      active <= '0;
      idx    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      unique case (state)
        IDLE: begin
          if (p_valid) begin
            active <= p_data;
            idx    <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (last_xfer) begin
            idx <= '0;
            if (pend_full)    active <= pend_q;
            else if (p_valid) active <= p_data;
            else begin
              // Final shift leaves ACTIVE all-zero while idle.
              active <= active >> WW;
              state  <= IDLE;
            end
          end else if (xfer) begin
            active <= active >> WW;
            idx    <= idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_valid = streaming;
  assign o_last  = streaming && (idx == LAST_IDX);
  assign o_data  = active[WW-1:0];

endmodule

// File: tb/tb_booth_unload.sv
// Table-driven bench for booth_unload: each record holds the inputs to drive
// for one cycle and the outputs expected at the start of that cycle.
module tb_booth_unload;

  localparam int PW = 448;
  localparam int WW = 32;
  localparam int NW = PW / WW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p_valid = 1'b0;
  logic [PW-1:0] p_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [WW-1:0] o_data;
  logic          o_last;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  booth_unload #(.PW(PW), .WW(WW)) dut (
    .clk     (clk),
    .rst     (rst),
    .p_valid (p_valid),
    .p_data  (p_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst;
    logic          pv;
    logic [PW-1:0] pd;
    logic          rdy;
    logic          clr;
    logic          chk;
    logic          dchk;
    logic          ev;
    logic [WW-1:0] ed;
    logic          el;
    logic          eovf;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Product whose word k equals base+k.
  function automatic logic [PW-1:0] mk_prod(input logic [WW-1:0] base);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < NW; k++) p[k*WW +: WW] = base + WW'(k);
    return p;
  endfunction

  function automatic vec_t v_reset();
    vec_t t;
    t = '0;
    t.chk  = 1'b1;
    t.dchk = 1'b1;
    return t;
  endfunction

  function automatic vec_t v_idle(input logic eo);
    vec_t t;
    t = '0;
    t.chk  = 1'b1;
    t.eovf = eo;
    return t;
  endfunction

  function automatic vec_t v_word(input logic [WW-1:0] d, input logic last, input logic eo);
    vec_t t;
    t = '0;
    t.chk  = 1'b1;
    t.dchk = 1'b1;
    t.ev   = 1'b1;
    t.ed   = d;
    t.el   = last;
    t.eovf = eo;
    return t;
  endfunction

  initial begin
    vec_t t;
    vec_t cur;
    int   w;

    // Product 0x1, ready held high: 14 words, only word 0 nonzero, then idle.
    t = '0; t.rst = 1'b1; vq.push_back(t);
    t = v_reset(); t.pv = 1'b1; t.pd = PW'(1); t.rdy = 1'b1; vq.push_back(t);
    for (int k = 0; k < NW; k++) begin
      t = v_word((k == 0) ? 32'h1 : 32'h0, k == NW - 1, 1'b0); t.rdy = 1'b1; vq.push_back(t);
    end

    // Words 0xA0..0xAD with ready toggling: 27 cycles, data held while stalled.
    t = v_idle(1'b0); t.pv = 1'b1; t.pd = mk_prod(32'hA0); vq.push_back(t);
    for (int c = 0; c < 27; c++) begin
      w = (c + 1) / 2;
      t = v_word(32'hA0 + WW'(w), w == NW - 1, 1'b0); t.rdy = (c % 2 == 0); vq.push_back(t);
    end

    // A, then B five cycles later: 28 words back to back.
    t = v_idle(1'b0); t.pv = 1'b1; t.pd = mk_prod(32'h1000); t.rdy = 1'b1; vq.push_back(t);
    for (int c = 1; c <= 2 * NW; c++) begin
      w = (c - 1) % NW;
      t = v_word(((c <= NW) ? 32'h1000 : 32'h2000) + WW'(w), w == NW - 1, 1'b0);
      t.rdy = 1'b1;
      if (c == 5) begin t.pv = 1'b1; t.pd = mk_prod(32'h2000); end
      vq.push_back(t);
    end

    // Three pulses while stalled: third dropped (drop beats a same-cycle clear).
    t = v_idle(1'b0); t.pv = 1'b1; t.pd = mk_prod(32'h3000); vq.push_back(t);
    t = v_word(32'h3000, 1'b0, 1'b0); t.pv = 1'b1; t.pd = mk_prod(32'h4000); vq.push_back(t);
    t = v_word(32'h3000, 1'b0, 1'b0); t.pv = 1'b1; t.pd = mk_prod(32'h5000); t.clr = 1'b1; vq.push_back(t);
    t = v_word(32'h3000, 1'b0, 1'b1); t.clr = 1'b1; vq.push_back(t);
    for (int c = 0; c < 2 * NW; c++) begin
      w = c % NW;
      t = v_word(((c < NW) ? 32'h3000 : 32'h4000) + WW'(w), w == NW - 1, 1'b0);
      t.rdy = 1'b1; vq.push_back(t);
    end

    // B pending, C arrives on A's last transfer: A, B, C with no gaps.
    t = v_idle(1'b0); t.pv = 1'b1; t.pd = mk_prod(32'h6000); t.rdy = 1'b1; vq.push_back(t);
    for (int c = 1; c <= 3 * NW; c++) begin
      w = (c - 1) % NW;
      t = v_word(((c <= NW) ? 32'h6000 : (c <= 2 * NW) ? 32'h7000 : 32'h8000) + WW'(w),
                 w == NW - 1, 1'b0);
      t.rdy = 1'b1;
      if (c == 1)  begin t.pv = 1'b1; t.pd = mk_prod(32'h7000); end
      if (c == NW) begin t.pv = 1'b1; t.pd = mk_prod(32'h8000); end
      vq.push_back(t);
    end

    // PENDING empty, next product arrives on the last transfer: no idle cycle.
    t = v_idle(1'b0); t.pv = 1'b1; t.pd = mk_prod(32'h9000); t.rdy = 1'b1; vq.push_back(t);
    for (int c = 1; c <= 2 * NW; c++) begin
      w = (c - 1) % NW;
      t = v_word(((c <= NW) ? 32'h9000 : 32'hB000) + WW'(w), w == NW - 1, 1'b0);
      t.rdy = 1'b1;
      if (c == NW) begin t.pv = 1'b1; t.pd = mk_prod(32'hB000); end
      vq.push_back(t);
    end

    // Reset at word 6 with B pending and a pulse during reset: all discarded.
    t = v_idle(1'b0); t.pv = 1'b1; t.pd = mk_prod(32'hC000); t.rdy = 1'b1; vq.push_back(t);
    for (int c = 1; c <= 7; c++) begin
      t = v_word(32'hC000 + WW'(c - 1), 1'b0, 1'b0); t.rdy = 1'b1;
      if (c == 1) begin t.pv = 1'b1; t.pd = mk_prod(32'hF000); end
      if (c == 7) begin t.rst = 1'b1; t.pv = 1'b1; t.pd = mk_prod(32'hD000); end
      vq.push_back(t);
    end
    t = v_reset(); t.rdy = 1'b1; vq.push_back(t);
    t = v_reset(); t.rdy = 1'b1; t.pv = 1'b1; t.pd = mk_prod(32'hE000); vq.push_back(t);
    for (int k = 0; k < NW; k++) begin
      t = v_word(32'hE000 + WW'(k), k == NW - 1, 1'b0); t.rdy = 1'b1; vq.push_back(t);
    end
    t = v_idle(1'b0); vq.push_back(t);

    // Each record: compare outputs at the falling edge, then drive its inputs.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      step = i;
      cur  = vq[i];
      if (cur.chk) begin
        check("o_valid", WW'(o_valid), WW'(cur.ev));
        check("o_last",  WW'(o_last),  WW'(cur.el));
        check("ovf",     WW'(ovf),     WW'(cur.eovf));
        if (cur.dchk) check("o_data", o_data, cur.ed);
      end
      rst     = cur.rst;
      p_valid = cur.pv;
      p_data  = cur.pd;
      o_ready = cur.rdy;
      ovf_clr = cur.clr;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
